// File: rtl/square_arbiter.sv
// square_arbiter: round-robin sequencer sharing one combinational squarer among four requesters
module square_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] num_flat,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [N-1:0]      sq_num,
    input  logic [2*N-1:0]    sq_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*N-1:0]    out_result,
    output logic [1:0]        out_id
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
    state_t             state_q;
    logic [1:0]         ptr_q;
    logic [NREQ-1:0]    gnt_q;
    logic [N-1:0]       sq_num_q;
    logic               out_valid_q;
    logic [2*N-1:0]     out_result_q;
    logic [1:0]         out_id_q;
    logic [2*NREQ-1:0]  dbl;
    logic [NREQ-1:0]    rot;
    logic [1:0]         sel;
    // Rotate requests so the search starts at ptr, then map the first hit back to a requester index
    always_comb begin
        dbl = {req, req} >> ptr_q;
        rot = dbl[NREQ-1:0];
        sel = rot[0] ? ptr_q : rot[1] ? ptr_q + 2'd1 : rot[2] ? ptr_q + 2'd2 : ptr_q + 2'd3;
    end
    // Grant in IDLE, capture the square in CALC, hold the result until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            sq_num_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_id_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (|req) begin
                    sq_num_q <= num_flat[sel*N +: N];
                    out_id_q <= sel;
                    gnt_q    <= NREQ'(1) << sel;
                    ptr_q    <= sel + 2'd1;
                    state_q  <= CALC;
                end
                CALC: begin
                    gnt_q        <= '0;
                    out_result_q <= sq_result;
                    out_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gnt        = gnt_q;
    assign busy       = (state_q != IDLE);
    assign sq_num     = sq_num_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_id     = out_id_q;
endmodule

// File: tb/tb_square_arbiter.sv
// tb_square_arbiter: directed scenarios plus random traffic checked against a behavioural model
module tb_square_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] num_flat;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  sq_num;
    logic [15:0] sq_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [1:0]  out_id;
    int total = 0;
    int bad = 0;
    int gid[$];
    int gcyc[$];
    int res[$];
    int rid[$];
    int exp_r[4] = '{9, 25, 49, 81};
    int exp_f[4] = '{0, 3, 0, 3};
    always #5 clk = ~clk;
    assign sq_result = 16'(sq_num) * 16'(sq_num);
    square_arbiter #(.N(8), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .num_flat(num_flat), .gnt(gnt), .busy(busy),
        .sq_num(sq_num), .sq_result(sq_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_id(out_id)
    );
    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endfunction
    // Behavioural model: phase 0 waiting, 1 squaring, 2 result offered
    int       m_st = 0, m_ptr = 0, m_id = 0, m_res = 0, m_num = 0, m_i = 0;
    bit [3:0] m_gnt = 0;
    bit       m_valid = 0;
    bit       model_on = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_ptr = 0; m_gnt = 0; m_num = 0; m_valid = 0; m_res = 0; m_id = 0;
        end else if (m_st == 0) begin
            m_gnt = 0;
            if (req != 0) begin
                for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) m_i = (m_ptr + k) % 4;
                m_num = int'(num_flat[m_i*8 +: 8]);
                m_id = m_i;
                m_gnt = 4'(1 << m_i);
                m_ptr = (m_i + 1) % 4;
                m_st = 1;
            end
        end else if (m_st == 1) begin
            m_gnt = 0;
            m_res = m_num * m_num;
            m_valid = 1;
            m_st = 2;
        end else if (out_ready) begin
            m_valid = 0;
            m_st = 0;
        end
    end
    always @(negedge clk) begin
        if (model_on) begin
            check("gnt", gnt, m_gnt);
            check("busy", busy, m_st != 0);
            check("sq_num", sq_num, m_num);
            check("out_valid", out_valid, m_valid);
            check("out_result", out_result, m_res);
            check("out_id", out_id, m_id);
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    task automatic single(input int id, input int num, input int exp);
        num_flat[id*8 +: 8] = 8'(num);
        req = 4'(1 << id);
        out_ready = 1'b1;
        tick();
        check("single_gnt", gnt, 1 << id);
        req = 4'b0;
        tick();
        check("single_valid", out_valid, 1);
        check("single_result", out_result, exp);
        check("single_model", m_res, exp);
        check("single_id", out_id, id);
        tick();
        check("single_idle", busy, 0);
    endtask
    task automatic collect(input int cycles, input bit drop);
        gid.delete(); gcyc.delete(); res.delete(); rid.delete();
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (gnt != 0) begin
                gid.push_back($clog2(gnt));
                gcyc.push_back(c);
                if (drop) req = req & ~gnt;
            end
            if (out_valid) begin
                res.push_back(int'(out_result));
                rid.push_back(int'(out_id));
            end
        end
    endtask
    initial begin
        rst = 1'b1; req = '0; num_flat = '0; out_ready = 1'b0;
        tick();
        tick();
        model_on = 1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sq_num", sq_num, 0);
        check("rst_result", out_result, 0);
        check("rst_id", out_id, 0);
        rst = 1'b0;
        num_flat[23:16] = 8'd15;
        req = 4'b0100;
        out_ready = 1'b1;
        tick();
        check("t1_gnt", gnt, 4);
        check("t1_model_gnt", m_gnt, 4);
        check("t1_busy", busy, 1);
        check("t1_sq_num", sq_num, 15);
        req = 4'b0;
        tick();
        check("t1_gnt_drop", gnt, 0);
        check("t1_valid", out_valid, 1);
        check("t1_result", out_result, 225);
        check("t1_model_res", m_res, 225);
        check("t1_id", out_id, 2);
        tick();
        check("t1_valid_fall", out_valid, 0);
        check("t1_busy_fall", busy, 0);
        single(0, 255, 65025);
        single(0, 0, 0);
        single(0, 1, 1);
        do_reset();
        num_flat = {8'd9, 8'd7, 8'd5, 8'd3};
        req = 4'hF;
        out_ready = 1'b1;
        collect(20, 1);
        check("t3_ngrants", gid.size(), 4);
        check("t3_nresults", res.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("t3_order", k < gid.size() ? gid[k] : -1, k);
            check("t3_result", k < res.size() ? res[k] : -1, exp_r[k]);
            check("t3_id", k < rid.size() ? rid[k] : -1, k);
            if (k > 0) check("t3_spacing", k < gcyc.size() ? gcyc[k] - gcyc[k-1] : -1, 3);
        end
        do_reset();
        req = 4'b1001;
        collect(14, 0);
        check("t4_ngrants", gid.size() >= 4, 1);
        for (int k = 0; k < 4; k++) check("t4_order", k < gid.size() ? gid[k] : -1, exp_f[k]);
        req = 4'b0;
        tick();
        tick();
        tick();
        do_reset();
        num_flat[7:0] = 8'd12;
        req = 4'b0001;
        out_ready = 1'b0;
        tick();
        check("t5_gnt", gnt, 1);
        req = 4'hF;
        tick();
        check("t5_valid", out_valid, 1);
        check("t5_result", out_result, 144);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_result", out_result, 144);
            check("t5_hold_id", out_id, 0);
            check("t5_hold_gnt", gnt, 0);
        end
        out_ready = 1'b1;
        tick();
        check("t5_accept_valid", out_valid, 0);
        check("t5_accept_busy", busy, 0);
        check("t5_accept_gnt", gnt, 0);
        req = 4'b0;
        tick();
        do_reset();
        req = 4'b0100;
        out_ready = 1'b0;
        tick();
        req = 4'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6c_valid", out_valid, 0);
        check("t6c_gnt", gnt, 0);
        check("t6c_busy", busy, 0);
        req = 4'hF;
        tick();
        check("t6c_regrant", gnt, 1);
        req = 4'b0;
        tick();
        check("t6h_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6h_valid", out_valid, 0);
        check("t6h_gnt", gnt, 0);
        check("t6h_busy", busy, 0);
        req = 4'hF;
        tick();
        check("t6h_regrant", gnt, 1);
        req = 4'b0;
        out_ready = 1'b1;
        tick();
        tick();
        for (int c = 0; c < 3000; c++) begin
            req = 4'($urandom);
            num_flat = $urandom;
            out_ready = ($urandom % 4) != 0;
            rst = ($urandom % 100) == 0;
            tick();
        end
        rst = 1'b0;
        req = 4'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/square_arbiter.md
Name: square_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational N-bit squarer among 4 requesters. It accepts one operand at a time, drives it to the shared squarer and captures the 2N-bit result. The result is held on a valid/ready output port tagged with the requester ID. The block sits between requester logic and the single squarer instance, so only one multiplier is needed in the datapath.

Parameters:
N, 8, operand width in bits; result width is 2*N.
NREQ, 4, number of requesters; fixed at 4, ID width 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  4  request per requester; bit i high = requester i has an operand.
num_flat  input  4*N  operands; requester i operand at bits [i*N +: N].
gnt  output  4  one-hot, one-cycle pulse; operand of requester i accepted.
busy  output  1  high whenever the FSM is not in IDLE.
sq_num  output  N  operand driven to the shared squarer (registered).
sq_result  input  2*N  squarer output; combinational function of sq_num.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result when high together with out_valid.
out_result  output  2*N  captured square.
out_id  output  2  index of the requester that owns out_result.

Behaviour:
- Reset (rst=1 at an edge), from any state:
  - state=IDLE, ptr=0.
  - gnt=0, busy=0, sq_num=0, out_valid=0, out_result=0, out_id=0.
  - Any in-flight operation is discarded; no result is produced for it.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - If req==0: stay in IDLE; outputs hold their values, gnt=0.
  - Else: select the first set req bit searching ptr, ptr+1, ... mod 4. Call it i.
  - At that edge: sq_num<=num_flat[i], out_id<=i, gnt<=(1<<i), ptr<=(i+1) mod 4, state<=CALC.
- CALC (exactly one cycle):
  - gnt is high for this cycle only and returns to 0 at the next edge.
  - At the edge: out_result<=sq_result, out_valid<=1, state<=HOLD.
  - req is ignored.
- HOLD:
  - out_valid, out_result and out_id stay stable until handshake.
  - On an edge with out_ready=1: out_valid<=0, state<=IDLE.
  - No new grant is issued in the same edge; minimum spacing is 3 cycles per result.
- busy = (state != IDLE), registered consistently with the state.
- Latency:
  - req sampled at edge k.
  - gnt high in cycle k..k+1.
  - out_valid rises at edge k+1.
  - If out_ready is held high, out_valid falls at edge k+2.
- Requester rule: keep req and operand stable until gnt is seen. Drop req the cycle after gnt unless another operand is pending.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- Round-robin:
  - ptr advances only on grant.
  - A continuously requesting requester waits at most 3 other grants.
- Width:
  - out_result is the full 2N-bit square; no truncation.
  - The maximum operand (2^N-1) gives (2^N-1)^2, which fits in 2N bits.
- Simultaneous events:
  - All req high in IDLE → only one grant, chosen by ptr.
  - rst has priority over out_ready and req.
- Outputs are registered; no combinational path from req or out_ready to any output.

Test Plan:
1. Reset, then single requester 2 with num=15, out_ready=1 → gnt=4'b0100 for one cycle; out_valid one cycle later; out_result=225; out_id=2; busy returns to 0.
2. Boundary operands via requester 0, N=8: num=255 → 65025 (16'hFE01); num=0 → 0; num=1 → 1.
3. All 4 req held high after reset, operands 3,5,7,9 (req i drops after its gnt) → grants in order 0,1,2,3; results 9,25,49,81 with matching out_id; each spaced 3 cycles.
4. Fairness: req[0] and req[3] continuously high → grant sequence 0,3,0,3; no requester is granted twice in a row while the other waits.
5. Backpressure: result 144 (num=12) with out_ready=0 for 5 cycles → out_valid, out_result=144 and out_id stay stable; no gnt issued; single accept when out_ready=1, then IDLE.
6. rst asserted during CALC and, separately, during HOLD → next cycle out_valid=0, gnt=0, busy=0, ptr=0; first later request with all req high is granted to requester 0.
